// File: rtl/alarm_ctrl.sv
// Mode/alarm controller for the HH:MM clock: key-driven time and alarm editing,
// counter load strobe, display routing, and a bounded alarm ring on time match.
module alarm_ctrl #(
    parameter int unsigned RING_SECS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       alarm_en,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [2:0] mode_state,
    output logic       load_en,
    output logic [3:0] load_h1,
    output logic [3:0] load_h0,
    output logic [3:0] load_m1,
    output logic [3:0] load_m0,
    output logic [3:0] alarm_h1,
    output logic [3:0] alarm_h0,
    output logic [3:0] alarm_m1,
    output logic [3:0] alarm_m0,
    output logic [3:0] disp_h1,
    output logic [3:0] disp_h0,
    output logic [3:0] disp_m1,
    output logic [3:0] disp_m0,
    output logic       disp_sel,
    output logic       blink,
    output logic [1:0] bee_req
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4,
        RING   = 3'd5
    } state_t;

    localparam logic [8:0] RING_LIM = 9'(RING_SECS);

    state_t      state_q, state_d;
    logic [7:0]  e_hour_q, e_hour_d, e_min_q, e_min_d;
    logic [7:0]  al_hour_q, al_hour_d, al_min_q, al_min_d;
    logic [7:0]  ld_hour_q, ld_hour_d, ld_min_q, ld_min_d;
    logic        load_en_q, load_en_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic        fired_q, fired_d;
    logic [15:0] disp_q, disp_d;
    logic        disp_sel_q, disp_sel_d;
    logic        blink_q, blink_d;
    logic [1:0]  bee_q, bee_d;
    logic [7:0]  cur_hour, cur_min;

    assign cur_hour = {cur_h1, cur_h0};
    assign cur_min  = {cur_m1, cur_m0};

    // BCD increment helpers operating on packed {tens, units}.
    function automatic logic [7:0] inc_hour(input logic [7:0] h);
        if (h == 8'h23)            return 8'h00;
        else if (h[3:0] == 4'h9)   return {h[7:4] + 4'd1, 4'h0};
        else                       return {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [7:0] m);
        if (m[3:0] == 4'h9) begin
            if (m[7:4] == 4'h5)    return 8'h00;
            else                   return {m[7:4] + 4'd1, 4'h0};
        end else                   return {m[7:4], m[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d    = state_q;
        e_hour_d   = e_hour_q;
        e_min_d    = e_min_q;
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        ld_hour_d  = ld_hour_q;
        ld_min_d   = ld_min_q;
        load_en_d  = 1'b0;
        ring_cnt_d = ring_cnt_q;
        fired_d    = fired_q;
        bee_d      = 2'b00;
        blink_d    = 1'b0;
        disp_d     = {cur_hour, cur_min};
        disp_sel_d = 1'b0;

        // The fired latch only re-arms once the minute moves off the alarm minute.
        if (cur_min != al_min_q) fired_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_mode) begin
                    state_d  = SET_TH;
                    e_hour_d = cur_hour;
                    e_min_d  = cur_min;
                end else if (tick_1hz && alarm_en && !fired_q &&
                             cur_hour == al_hour_q && cur_min == al_min_q) begin
                    state_d    = RING;
                    fired_d    = 1'b1;
                    ring_cnt_d = 8'd0;
                    bee_d      = 2'b01;
                end
            end
            SET_TH: begin
                if (key_mode)     state_d  = SET_TM;
                else if (key_inc) e_hour_d = inc_hour(e_hour_q);
            end
            SET_TM: begin
                if (key_mode) begin
                    state_d   = SET_AH;
                    load_en_d = 1'b1;
                    ld_hour_d = e_hour_q;
                    ld_min_d  = e_min_q;
                end else if (key_inc) begin
                    e_min_d = inc_min(e_min_q);
                end
            end
            SET_AH: begin
                if (key_mode)     state_d   = SET_AM;
                else if (key_inc) al_hour_d = inc_hour(al_hour_q);
            end
            SET_AM: begin
                if (key_mode)     state_d  = IDLE;
                else if (key_inc) al_min_d = inc_min(al_min_q);
            end
            RING: begin
                if (key_mode || key_inc || !alarm_en) begin
                    state_d = IDLE;
                end else if (tick_1hz) begin
                    if ({1'b0, ring_cnt_q} + 9'd1 == RING_LIM) begin
                        state_d = IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                        bee_d      = (bee_q == 2'b01) ? 2'b10 : 2'b01;
                    end
                end else begin
                    bee_d = bee_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the post-edge state so they align with mode_state.
        case (state_d)
            SET_TH, SET_TM: begin
                disp_d = {e_hour_d, e_min_d};
                if (state_d != state_q) blink_d = 1'b1;
                else                    blink_d = tick_1hz ? ~blink_q : blink_q;
            end
            SET_AH, SET_AM: begin
                disp_d     = {al_hour_d, al_min_d};
                disp_sel_d = 1'b1;
                if (state_d != state_q) blink_d = 1'b1;
                else                    blink_d = tick_1hz ? ~blink_q : blink_q;
            end
            RING:    blink_d = 1'b1;
            default: blink_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            e_hour_q   <= 8'h00;
            e_min_q    <= 8'h00;
            al_hour_q  <= 8'h00;
            al_min_q   <= 8'h00;
            ld_hour_q  <= 8'h00;
            ld_min_q   <= 8'h00;
            load_en_q  <= 1'b0;
            ring_cnt_q <= 8'd0;
            fired_q    <= 1'b0;
            disp_q     <= 16'h0000;
            disp_sel_q <= 1'b0;
            blink_q    <= 1'b0;
            bee_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            e_hour_q   <= e_hour_d;
            e_min_q    <= e_min_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            ld_hour_q  <= ld_hour_d;
            ld_min_q   <= ld_min_d;
            load_en_q  <= load_en_d;
            ring_cnt_q <= ring_cnt_d;
            fired_q    <= fired_d;
            disp_q     <= disp_d;
            disp_sel_q <= disp_sel_d;
            blink_q    <= blink_d;
            bee_q      <= bee_d;
        end
    end

    assign mode_state = state_q;
    assign load_en    = load_en_q;
    assign {load_h1, load_h0}   = ld_hour_q;
    assign {load_m1, load_m0}   = ld_min_q;
    assign {alarm_h1, alarm_h0} = al_hour_q;
    assign {alarm_m1, alarm_m0} = al_min_q;
    assign {disp_h1, disp_h0, disp_m1, disp_m0} = disp_q;
    assign disp_sel   = disp_sel_q;
    assign blink      = blink_q;
    assign bee_req    = bee_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: editing, load strobe, alarm ring, key priority
// and reset override, with hand-computed expectations.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, tick_1hz, key_mode, key_inc, alarm_en;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
    logic [2:0] mode_state;
    logic       load_en, disp_sel, blink;
    logic [3:0] load_h1, load_h0, load_m1, load_m0;
    logic [3:0] alarm_h1, alarm_h0, alarm_m1, alarm_m0;
    logic [3:0] disp_h1, disp_h0, disp_m1, disp_m0;
    logic [1:0] bee_req;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(.RING_SECS(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .key_mode(key_mode), .key_inc(key_inc), .alarm_en(alarm_en),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .mode_state(mode_state), .load_en(load_en),
        .load_h1(load_h1), .load_h0(load_h0), .load_m1(load_m1), .load_m0(load_m0),
        .alarm_h1(alarm_h1), .alarm_h0(alarm_h0), .alarm_m1(alarm_m1), .alarm_m0(alarm_m0),
        .disp_h1(disp_h1), .disp_h0(disp_h0), .disp_m1(disp_m1), .disp_m0(disp_m0),
        .disp_sel(disp_sel), .blink(blink), .bee_req(bee_req)
    );

    wire [15:0] disp_w  = {disp_h1, disp_h0, disp_m1, disp_m0};
    wire [15:0] alarm_w = {alarm_h1, alarm_h0, alarm_m1, alarm_m0};
    wire [15:0] load_w  = {load_h1, load_h0, load_m1, load_m0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given one-cycle pulses; returns with outputs settled.
    task automatic cyc(input logic m, input logic i, input logic t);
        @(negedge clk);
        key_mode = m; key_inc = i; tick_1hz = t;
        @(posedge clk);
        #1;
        key_mode = 1'b0; key_inc = 1'b0; tick_1hz = 1'b0;
        $display("cyc mode=%0b inc=%0b tick=%0b -> state=%0d bee=%0d disp=%h", m, i, t,
                 mode_state, bee_req, disp_w);
    endtask

    task automatic set_cur(input logic [15:0] v);
        @(negedge clk);
        {cur_h1, cur_h0, cur_m1, cur_m0} = v;
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0; alarm_en = 1'b0;
        {cur_h1, cur_h0, cur_m1, cur_m0} = 16'h0000;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", 16'(mode_state), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 0);
        chk("rel_mode", 16'(mode_state), 16'd0);
        chk("rel_bee", 16'(bee_req), 16'd0);
        chk("rel_alarm", alarm_w, 16'h0000);
        chk("rel_load", {15'd0, load_en}, 16'd0);
        chk("rel_blink_sel", {14'd0, blink, disp_sel}, 16'd0);
        chk("rel_disp", disp_w, 16'h0000);

        // Time edit with wraps and load strobe
        set_cur(16'h1025);
        cyc(0, 1, 0);
        chk("idle_inc_ignored", 16'(mode_state), 16'd0);
        cyc(1, 0, 0);
        chk("th_mode", 16'(mode_state), 16'd1);
        chk("th_disp", disp_w, 16'h1025);
        chk("th_blink_entry", 16'(blink), 16'd1);
        cyc(0, 0, 1);
        chk("th_blink_tick", 16'(blink), 16'd0);
        repeat (14) cyc(0, 1, 0);
        chk("th_hour_wrap", disp_w, 16'h0025);
        cyc(1, 0, 0);
        chk("tm_mode", 16'(mode_state), 16'd2);
        chk("tm_blink_entry", 16'(blink), 16'd1);
        chk("tm_no_load", 16'(load_en), 16'd0);
        repeat (35) cyc(0, 1, 0);
        chk("tm_min_wrap", disp_w, 16'h0000);
        cyc(1, 0, 0);
        chk("ah_mode", 16'(mode_state), 16'd3);
        chk("ah_load_en", 16'(load_en), 16'd1);
        chk("ah_load_val", load_w, 16'h0000);
        chk("ah_disp_sel", 16'(disp_sel), 16'd1);
        cyc(0, 0, 0);
        chk("ah_load_once", 16'(load_en), 16'd0);

        // Alarm set to 07:30 and ring
        repeat (7) cyc(0, 1, 0);
        chk("ah_hour", alarm_w, 16'h0700);
        cyc(1, 0, 0);
        chk("am_mode", 16'(mode_state), 16'd4);
        repeat (30) cyc(0, 1, 0);
        chk("am_min", alarm_w, 16'h0730);
        chk("am_disp", disp_w, 16'h0730);
        cyc(1, 0, 0);
        chk("back_idle", 16'(mode_state), 16'd0);
        chk("idle_blink_sel", {14'd0, blink, disp_sel}, 16'd0);
        alarm_en = 1'b1;
        set_cur(16'h0730);
        cyc(0, 0, 0);
        chk("no_ring_without_tick", 16'(mode_state), 16'd0);
        cyc(0, 0, 1);
        chk("ring_mode", 16'(mode_state), 16'd5);
        chk("ring_bee0", 16'(bee_req), 16'd1);
        chk("ring_blink", 16'(blink), 16'd1);
        chk("ring_disp_cur", disp_w, 16'h0730);
        cyc(0, 0, 0);
        chk("ring_bee_hold", 16'(bee_req), 16'd1);
        cyc(0, 0, 1);
        chk("ring_bee1", 16'(bee_req), 16'd2);
        cyc(0, 0, 1);
        chk("ring_bee2", 16'(bee_req), 16'd1);
        cyc(0, 0, 1);
        chk("ring_bee3", 16'(bee_req), 16'd2);
        chk("ring_still", 16'(mode_state), 16'd5);
        cyc(0, 0, 1);
        chk("ring_timeout_mode", 16'(mode_state), 16'd0);
        chk("ring_timeout_bee", 16'(bee_req), 16'd0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("no_rering", 16'(mode_state), 16'd0);

        // Key acknowledge, then alarm_en drop
        set_cur(16'h0731);
        set_cur(16'h0730);
        cyc(0, 0, 1);
        chk("ring2_mode", 16'(mode_state), 16'd5);
        cyc(0, 1, 0);
        chk("ack_mode", 16'(mode_state), 16'd0);
        chk("ack_bee", 16'(bee_req), 16'd0);
        chk("ack_alarm", alarm_w, 16'h0730);
        set_cur(16'h0731);
        set_cur(16'h0730);
        cyc(0, 0, 1);
        chk("ring3_mode", 16'(mode_state), 16'd5);
        @(negedge clk) alarm_en = 1'b0;
        cyc(0, 0, 0);
        chk("en_drop_mode", 16'(mode_state), 16'd0);
        chk("en_drop_bee", 16'(bee_req), 16'd0);
        alarm_en = 1'b1;

        // Simultaneous keys: mode wins
        set_cur(16'h0500);
        cyc(1, 0, 0);
        chk("th2_disp", disp_w, 16'h0500);
        cyc(1, 1, 0);
        chk("both_mode", 16'(mode_state), 16'd2);
        chk("both_hour_kept", disp_w, 16'h0500);
        cyc(1, 0, 0);
        chk("ah2_load", load_w, 16'h0500);
        cyc(1, 0, 0);
        chk("am2_mode", 16'(mode_state), 16'd4);

        // Reset in SET_AM
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_am_mode", 16'(mode_state), 16'd0);
        chk("rst_am_alarm", alarm_w, 16'h0000);
        chk("rst_am_load", 16'(load_en), 16'd0);
        chk("rst_am_sel", 16'(disp_sel), 16'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset in RING
        set_cur(16'h0000);
        cyc(0, 0, 1);
        chk("ring4_mode", 16'(mode_state), 16'd5);
        cyc(0, 0, 1);
        chk("ring4_bee", 16'(bee_req), 16'd2);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_ring_mode", 16'(mode_state), 16'd0);
        chk("rst_ring_bee", 16'(bee_req), 16'd0);
        chk("rst_ring_blink", 16'(blink), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 0);
        chk("post_rst_mode", 16'(mode_state), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
